mips_gpp_top: RTL and testbench



---
 rtl/mips_gpp_pkg.sv | 58 +++++
 rtl/mips_gpp_regfile.sv | 33 +++
 rtl/mips_gpp_sram.sv | 55 +++++
 rtl/mips_gpp_top.sv | 256 +++++++++++++++++++++++++
 tb/tb_mips_gpp_top.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_gpp_pkg.sv
// mips_gpp_pkg: shared widths, FSM state codes, opcode/funct constants,
// ALU operation enum and instruction field layout for the multi-cycle
// MIPS-subset core.
package mips_gpp_pkg;

    localparam int D_WIDTH  = 32;
    localparam int SA_WIDTH = 5;
    localparam int SL_WIDTH = 1 << SA_WIDTH;
    localparam int RF_AW    = 5;

    localparam logic [2:0] S_wait      = 3'd0;
    localparam logic [2:0] S_initial   = 3'd1;
    localparam logic [2:0] S_fetch     = 3'd2;
    localparam logic [2:0] S_decode    = 3'd3;
    localparam logic [2:0] S_execute   = 3'd4;
    localparam logic [2:0] S_mem       = 3'd5;
    localparam logic [2:0] S_writeback = 3'd6;
    localparam logic [2:0] S_done      = 3'd7;

    localparam logic [D_WIDTH-1:0] HALT_INSTR = 32'hFC00_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = HALT_INSTR[31:26];

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_NONE
    } aluOp_t;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

    function automatic logic [D_WIDTH-1:0] signExt16(input logic [15:0] imm);
        return {{(D_WIDTH-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_gpp_regfile.sv
// gpp_regfile: 32 x 32 register file, two combinational read ports and one
// write port. Register 0 reads as zero and ignores writes.
module gpp_regfile
    import mips_gpp_pkg::*;
(
    input  logic               clk_i,
    input  logic               clear_i,
    input  logic [RF_AW-1:0]   raddrA_i,
    input  logic [RF_AW-1:0]   raddrB_i,
    output logic [D_WIDTH-1:0] rdataA_o,
    output logic [D_WIDTH-1:0] rdataB_o,
    input  logic               we_i,
    input  logic [RF_AW-1:0]   waddr_i,
    input  logic [D_WIDTH-1:0] wdata_i
);

    logic [D_WIDTH-1:0] regs_q [32];

    // Register storage with clear; writes to register 0 are dropped
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdataA_o = (raddrA_i == '0) ? '0 : regs_q[raddrA_i];
    assign rdataB_o = (raddrB_i == '0) ? '0 : regs_q[raddrB_i];

endmodule

// File: rtl/mips_gpp_sram.sv
// gpp_sram: single-port word-addressed synchronous SRAM shared by host and
// core. The one address port feeds two read registers: one for core fetch /
// load, one for the host, so host read data survives a program run.
module gpp_sram
    import mips_gpp_pkg::*;
(
    input  logic                clk_i,
    input  logic                clear_i,
    input  logic                rdClr_i,
    input  logic [SA_WIDTH-1:0] addr_i,
    input  logic                we_i,
    input  logic [D_WIDTH-1:0]  wdata_i,
    input  logic                coreRe_i,
    input  logic                hostRe_i,
    output logic [D_WIDTH-1:0]  coreRdata_o,
    output logic [D_WIDTH-1:0]  hostRdata_o
);

    logic [D_WIDTH-1:0] mem_q [SL_WIDTH];
    logic [D_WIDTH-1:0] coreRdata_q;
    logic [D_WIDTH-1:0] hostRdata_q;

    // Storage array: whole-array clear has priority over a write
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            for (int i = 0; i < SL_WIDTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Core read register, loaded on fetch and load cycles only
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            coreRdata_q <= '0;
        end else if (coreRe_i) begin
            coreRdata_q <= mem_q[addr_i];
        end
    end

    // Host read register, holds its value between host reads
    always_ff @(posedge clk_i) begin
        if (clear_i || rdClr_i) begin
            hostRdata_q <= '0;
        end else if (hostRe_i) begin
            hostRdata_q <= mem_q[addr_i];
        end
    end

    assign coreRdata_o = coreRdata_q;
    assign hostRdata_o = hostRdata_q;

endmodule

// File: rtl/mips_gpp_top.sv
// mips_gpp_top: multi-cycle MIPS-subset processor with one shared SRAM that
// is loaded by a host while idle. Optional macro GPP_READBACK_EN enables the
// host read path; without it Data_O is tied to 0 and host reads are ignored.
module mips_gpp_top
    import mips_gpp_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Rst_M,
    input  logic                Str,
    input  logic [SA_WIDTH-1:0] Addr,
    input  logic [D_WIDTH-1:0]  Data_I,
    output logic [D_WIDTH-1:0]  Data_O,
    input  logic                En,
    input  logic                RW,
    output logic                Done
);

    localparam logic [SA_WIDTH-1:0] PC_ONE = SA_WIDTH'(1);

    logic [2:0]          state_q, state_d;
    logic [SA_WIDTH-1:0] pc_q, pc_d;
    logic [D_WIDTH-1:0]  ir_q, ir_d;
    logic [D_WIDTH-1:0]  a_q, a_d;
    logic [D_WIDTH-1:0]  b_q, b_d;
    logic [D_WIDTH-1:0]  aluOut_q, aluOut_d;

    instr_t              ins;
    logic [D_WIDTH-1:0]  immExt;
    aluOp_t              aluOp;
    logic [D_WIDTH-1:0]  aluB;
    logic [D_WIDTH-1:0]  aluRes;

    logic [SA_WIDTH-1:0] memAddr;
    logic                memWeRaw, memWe;
    logic [D_WIDTH-1:0]  memWdata;
    logic                coreRe;
    logic                hostReRaw, hostRe;
    logic [D_WIDTH-1:0]  coreRdata, hostRdata;

    logic [RF_AW-1:0]    rfAddrA, rfAddrB, rfWaddr;
    logic [D_WIDTH-1:0]  rfDataA, rfDataB, rfWdata;
    logic                rfWeRaw, rfWe, rfClear;

    logic                abortNow;
    logic                unusedBits;

    assign ins        = instr_t'(ir_q);
    assign immExt     = signExt16(ir_q[15:0]);
    assign abortNow   = Rst | Rst_M;
    assign unusedBits = ^{ins.rs, ins.shamt};

    assign memWe   = memWeRaw & ~abortNow;
    assign rfWe    = rfWeRaw & ~abortNow;
    assign rfClear = Rst & ~Rst_M;

    // Operands are read while the instruction word sits in the SRAM read register
    assign rfAddrA = coreRdata[25:21];
    assign rfAddrB = coreRdata[20:16];

`ifdef GPP_READBACK_EN
    assign hostRe = hostReRaw & ~abortNow;
    assign Data_O = hostRdata;
`else
    logic unusedReadback;
    assign hostRe         = 1'b0;
    assign Data_O         = '0;
    assign unusedReadback = ^{hostRdata, hostReRaw};
`endif

    assign Done = (state_q == S_done);

    gpp_sram u_sram (
        .clk_i       (Clk),
        .clear_i     (Rst_M),
        .rdClr_i     (Rst),
        .addr_i      (memAddr),
        .we_i        (memWe),
        .wdata_i     (memWdata),
        .coreRe_i    (coreRe),
        .hostRe_i    (hostRe),
        .coreRdata_o (coreRdata),
        .hostRdata_o (hostRdata)
    );

    gpp_regfile u_regfile (
        .clk_i    (Clk),
        .clear_i  (rfClear),
        .raddrA_i (rfAddrA),
        .raddrB_i (rfAddrB),
        .rdataA_o (rfDataA),
        .rdataB_o (rfDataB),
        .we_i     (rfWe),
        .waddr_i  (rfWaddr),
        .wdata_i  (rfWdata)
    );

    // ALU operation select: unknown funct codes decode to ALU_NONE (NOP)
    always_comb begin
        aluOp = ALU_NONE;
        aluB  = b_q;
        case (ins.opcode)
            OP_RTYPE: begin
                case (ins.funct)
                    FN_ADD:  aluOp = ALU_ADD;
                    FN_SUB:  aluOp = ALU_SUB;
                    FN_AND:  aluOp = ALU_AND;
                    FN_OR:   aluOp = ALU_OR;
                    FN_SLT:  aluOp = ALU_SLT;
                    default: aluOp = ALU_NONE;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                aluOp = ALU_ADD;
                aluB  = immExt;
            end
            default: aluOp = ALU_NONE;
        endcase
    end

    // ALU datapath, wrap-around two's complement, signed set-less-than
    always_comb begin
        case (aluOp)
            ALU_ADD: aluRes = a_q + aluB;
            ALU_SUB: aluRes = a_q - aluB;
            ALU_AND: aluRes = a_q & aluB;
            ALU_OR:  aluRes = a_q | aluB;
            ALU_SLT: aluRes = {{(D_WIDTH-1){1'b0}}, ($signed(a_q) < $signed(aluB))};
            default: aluRes = '0;
        endcase
    end

    // FSM next-state, PC update and SRAM/regfile port control
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        aluOut_d  = aluOut_q;
        memAddr   = Addr;
        memWeRaw  = 1'b0;
        memWdata  = Data_I;
        coreRe    = 1'b0;
        hostReRaw = 1'b0;
        rfWeRaw   = 1'b0;
        rfWaddr   = ins.rt;
        rfWdata   = aluOut_q;
        case (state_q)
            S_wait: begin
                memWeRaw  = En & RW;
                hostReRaw = En & ~RW;
                if (Str) begin
                    state_d = S_initial;
                end
            end
            S_initial: begin
                pc_d    = '0;
                state_d = S_fetch;
            end
            S_fetch: begin
                memAddr = pc_q;
                coreRe  = 1'b1;
                state_d = S_decode;
            end
            S_decode: begin
                ir_d    = coreRdata;
                a_d     = rfDataA;
                b_d     = rfDataB;
                state_d = S_execute;
            end
            S_execute: begin
                aluOut_d = aluRes;
                pc_d     = pc_q + PC_ONE;
                state_d  = S_fetch;
                case (ins.opcode)
                    OP_RTYPE: begin
                        if (aluOp != ALU_NONE) begin
                            pc_d    = pc_q;
                            state_d = S_writeback;
                        end
                    end
                    OP_ADDI: begin
                        pc_d    = pc_q;
                        state_d = S_writeback;
                    end
                    OP_LW, OP_SW: begin
                        pc_d    = pc_q;
                        state_d = S_mem;
                    end
                    OP_BEQ: begin
                        if (a_q == b_q) begin
                            pc_d = pc_q + PC_ONE + immExt[SA_WIDTH-1:0];
                        end
                    end
                    OP_J: begin
                        pc_d = ir_q[SA_WIDTH-1:0];
                    end
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = S_done;
                    end
                    default: begin
                        pc_d = pc_q + PC_ONE;
                    end
                endcase
            end
            S_mem: begin
                memAddr  = aluOut_q[SA_WIDTH-1:0];
                memWdata = b_q;
                if (ins.opcode == OP_SW) begin
                    memWeRaw = 1'b1;
                    pc_d     = pc_q + PC_ONE;
                    state_d  = S_fetch;
                end else begin
                    coreRe  = 1'b1;
                    state_d = S_writeback;
                end
            end
            S_writeback: begin
                rfWeRaw = 1'b1;
                rfWaddr = (ins.opcode == OP_RTYPE) ? ins.rd : ins.rt;
                rfWdata = (ins.opcode == OP_LW) ? coreRdata : aluOut_q;
                pc_d    = pc_q + PC_ONE;
                state_d = S_fetch;
            end
            S_done: begin
                memWeRaw  = En & RW;
                hostReRaw = En & ~RW;
            end
            default: begin
                state_d = S_wait;
            end
        endcase
    end

    // Control registers; either reset aborts the current instruction
    always_ff @(posedge Clk) begin
        if (abortNow) begin
            state_q  <= S_wait;
            pc_q     <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluOut_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluOut_q <= aluOut_d;
        end
    end

endmodule

// File: tb/tb_mips_gpp_top.sv
// tb_mips_gpp_top: directed bench for mips_gpp_top. Programs are written so
// that a wrong result changes the cycle count to Done or spins in a jump
// loop, so core results are observable with or without GPP_READBACK_EN.
module tb_mips_gpp_top;

    logic        Clk;
    logic        Rst;
    logic        Rst_M;
    logic        Str;
    logic [4:0]  Addr;
    logic [31:0] Data_I;
    logic [31:0] Data_O;
    logic        En;
    logic        RW;
    logic        Done;

    int errors;
    int checks;

    mips_gpp_top dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Rst_M  (Rst_M),
        .Str    (Str),
        .Addr   (Addr),
        .Data_I (Data_I),
        .Data_O (Data_O),
        .En     (En),
        .RW     (RW),
        .Done   (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] rdExp(input logic [31:0] v);
`ifdef GPP_READBACK_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic rw, input logic [4:0] a, input logic [31:0] d);
        En     = en;
        RW     = rw;
        Addr   = a;
        Data_I = d;
        tick();
        En     = 1'b0;
        RW     = 1'b0;
    endtask

    task automatic pulseMemReset();
        Rst_M = 1'b1;
        tick();
        Rst_M = 1'b0;
    endtask

    task automatic pulseCoreReset();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
    endtask

    task automatic runProgram(input int expCycles, input string tag);
        int cycles;
        Str = 1'b1;
        tick();
        Str = 1'b0;
        cycles = 0;
        while ((Done !== 1'b1) && (cycles < expCycles + 40)) begin
            tick();
            cycles++;
        end
        checkOutput(tag, 32'(cycles), 32'(expCycles));
    endtask

    initial begin : stimulus
        logic [31:0] p1 [5];
        logic [31:0] p2 [9];
        logic [31:0] p3 [17];

        errors = 0;
        checks = 0;
        Rst    = 1'b1;
        Rst_M  = 1'b0;
        Str    = 1'b0;
        En     = 1'b0;
        RW     = 1'b0;
        Addr   = '0;
        Data_I = '0;

        // reset state and cleared memory
        tick();
        Rst = 1'b0;
        pulseMemReset();
        checkOutput("resetDone", 32'(Done), 32'd0);
        checkOutput("resetDataO", Data_O, 32'd0);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b0, 5'(i), 32'h0);
            checkOutput($sformatf("clearRead%0d", i), Data_O, 32'h0);
        end

        // host load and readback, Str held low
        applyStimulus(1'b1, 1'b1, 5'd7, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 5'd7, 32'h0);
        checkOutput("hostRead7", Data_O, rdExp(32'hDEADBEEF));
        applyStimulus(1'b0, 1'b0, 5'd3, 32'h0);
        applyStimulus(1'b0, 1'b1, 5'd7, 32'h5555AAAA);
        checkOutput("dataOHold", Data_O, rdExp(32'hDEADBEEF));
        applyStimulus(1'b1, 1'b0, 5'd7, 32'h0);
        checkOutput("disabledWrite", Data_O, rdExp(32'hDEADBEEF));
        checkOutput("idleDone", 32'(Done), 32'd0);

        // program 1: addi/addi/add/sw/halt
        pulseMemReset();
        p1 = '{32'h20010005, 32'h20020007, 32'h00221820, 32'hAC03000A, 32'hFC000000};
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 5'(i), p1[i]);
        pulseCoreReset();
        runProgram(20, "prog1Cycles");
        checkOutput("prog1Done", 32'(Done), 32'd1);
        applyStimulus(1'b1, 1'b0, 5'd10, 32'h0);
        checkOutput("prog1Mem10", Data_O, rdExp(32'd12));
        for (int i = 0; i < 4; i++) begin
            Str = ~Str;
            tick();
            checkOutput("doneHold", 32'(Done), 32'd1);
        end
        Str = 1'b0;
        applyStimulus(1'b1, 1'b1, 5'd15, 32'h00001234);
        applyStimulus(1'b1, 1'b0, 5'd15, 32'h0);
        checkOutput("doneHostRW", Data_O, rdExp(32'h00001234));

        // program 2: slt of -1 vs 1, taken beq skips addi, two NOPs, sw
        pulseMemReset();
        p2 = '{32'h2001FFFF, 32'h20020001, 32'h0022182A, 32'h10620001, 32'h20030063,
               32'h00221821, 32'hF8000000, 32'hAC030014, 32'hFC000000};
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 5'(i), p2[i]);
        pulseCoreReset();
        runProgram(29, "prog2Cycles");
        checkOutput("prog2Done", 32'(Done), 32'd1);
        applyStimulus(1'b1, 1'b0, 5'd20, 32'h0);
        checkOutput("prog2Slt", Data_O, rdExp(32'd1));
        applyStimulus(1'b1, 1'b0, 5'd4, 32'h0);
        checkOutput("prog2Skipped", Data_O, rdExp(32'h20030063));

        // program 3: sw/lw round trip, sub/and/or checked by beq, j traps on error
        pulseMemReset();
        p3 = '{32'h2001000C, 32'h2002000A, 32'hAC01001E, 32'h8C04001E, 32'h00812822,
               32'h10A00001, 32'h08000006, 32'h00223024, 32'h00223825, 32'h20080008,
               32'h2009000E, 32'h10C80001, 32'h0800000C, 32'h10E90001, 32'h0800000E,
               32'hAC07001F, 32'hFC000000};
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b1, 5'(i), p3[i]);
        pulseCoreReset();
        runProgram(54, "prog3Cycles");
        applyStimulus(1'b1, 1'b0, 5'd30, 32'h0);
        checkOutput("prog3Mem30", Data_O, rdExp(32'd12));
        applyStimulus(1'b1, 1'b0, 5'd31, 32'h0);
        checkOutput("prog3Mem31", Data_O, rdExp(32'd14));

        // abort: Rst while sw is in execute must not commit the store
        pulseMemReset();
        applyStimulus(1'b1, 1'b1, 5'd0, 32'h20010037);
        applyStimulus(1'b1, 1'b1, 5'd1, 32'hAC010019);
        applyStimulus(1'b1, 1'b1, 5'd2, 32'hFC000000);
        applyStimulus(1'b1, 1'b1, 5'd8, 32'h8C020019);
        applyStimulus(1'b1, 1'b1, 5'd9, 32'h10400001);
        applyStimulus(1'b1, 1'b1, 5'd10, 32'h0800000A);
        applyStimulus(1'b1, 1'b1, 5'd11, 32'hFC000000);
        pulseCoreReset();
        Str = 1'b1;
        tick();
        Str = 1'b0;
        repeat (7) tick();
        pulseCoreReset();
        checkOutput("abortDone", 32'(Done), 32'd0);
        repeat (5) tick();
        checkOutput("abortIdle", 32'(Done), 32'd0);
        applyStimulus(1'b1, 1'b0, 5'd25, 32'h0);
        checkOutput("abortNoStore", Data_O, 32'h0);
        applyStimulus(1'b1, 1'b1, 5'd0, 32'h08000008);
        runProgram(15, "abortRecheck");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
